btn_debouncer: RTL and testbench
================================

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 1_000_000 (10 ms at 100 MHz); meaning: consecutive stable cycles required to accept a level change; legal range >= 2.
REQ-002 Port clk  input  1  system clock, rising-edge active; one clock only.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port btn_raw  input  1  raw mechanical push-button level, asynchronous to clk, bouncy.
REQ-005 Port btn_db  output  1  debounced, synchronised button level; drives the btn input of the downstream pulse generator.
REQ-006 Port rise  output  1  one-cycle strobe on each accepted 0->1 change of btn_db.
REQ-007 Port fall  output  1  one-cycle strobe on each accepted 1->0 change of btn_db.

Function
REQ-008 btn_raw SHALL pass through a 2-flop synchroniser; only the second flop output (btn_s) SHALL feed the FSM.
REQ-009 The FSM SHALL have four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-010 STABLE_LO: btn_s=1 -> WAIT_HI with counter cleared to 0; else stay.
REQ-011 WAIT_HI: btn_s=0 -> STABLE_LO with counter cleared; btn_s=1 and counter==CNT_MAX-1 -> STABLE_HI; otherwise counter increments by 1.
REQ-012 STABLE_HI and WAIT_LO SHALL mirror REQ-010/011 with levels inverted.
REQ-013 btn_db SHALL be registered: 1 in STABLE_HI and WAIT_LO, 0 in STABLE_LO and WAIT_HI.
REQ-014 Latency: a btn_raw change held stable SHALL change btn_db on the (CNT_MAX+3)th rising edge, counting the first edge that samples the new level as edge 1.
REQ-015 Any btn_raw excursion shorter than CNT_MAX cycles at btn_s SHALL leave btn_db, rise and fall unchanged.
REQ-016 A bounce back to the old level during WAIT_* SHALL restart qualification from zero on the next change; no partial count is retained.
REQ-017 rise (fall) SHALL be registered and high for exactly the one cycle in which btn_db first reads 1 (0); rise and fall SHALL never be high together.
REQ-018 The counter width SHALL be $clog2(CNT_MAX); the counter SHALL never exceed CNT_MAX-1 or wrap.
REQ-019 The counter SHALL hold 0 in both STABLE states.

Reset
REQ-020 rst low SHALL immediately, without a clock edge, set both synchroniser flops to 0, the state to STABLE_LO, the counter to 0, and btn_db, rise and fall to 0.
REQ-021 Reset asserted mid-qualification SHALL abort it; after release, qualification SHALL restart from STABLE_LO.
REQ-022 If btn_raw is held high through reset release, btn_db SHALL rise CNT_MAX+3 edges after release, with one rise strobe.

Structure
REQ-023 A shared package SHALL hold the state enum type and the default CNT_MAX constant.
REQ-024 The synchroniser SHALL be a separate sub-module sync_2ff (clk, rst, d, q), reusable for other asynchronous inputs.

Verification (clk 10 ns, CNT_MAX=4)
REQ-025 Reset: rst=0 for 20 ns with btn_raw=1 -> btn_db=rise=fall=0 throughout; after release btn_db rises at edge 7 with a single 10 ns rise pulse.
REQ-026 Clean press: btn_raw 0->1 held 100 ns -> btn_db=1 on the 7th edge, rise=1 for exactly that cycle; release held 100 ns -> btn_db=0 on the 7th edge, fall=1 for one cycle.
REQ-027 Bounce: btn_raw toggles 1,0,1,0 every 20 ns, then holds 1 -> btn_db stays 0 during bouncing and rises 7 edges after the final 0->1; exactly one rise.
REQ-028 Glitch: btn_raw high for 30 ns (3 cycles) -> btn_db, rise and fall remain 0.
REQ-029 Reset mid-qualification: rst pulled low at edge 5 of a press -> outputs 0 immediately; with btn_raw still 1, btn_db rises at edge 7 after release.
REQ-030 Integration: btn_db drives the pulse generator's btn; a 500 ns bouncy press -> exactly one pulse output from the pulse generator.

Source files
------------

// File: rtl/btn_debouncer_pkg.sv
// ============================================================================
// Module      : btn_debouncer_pkg
// Description : Shared FSM state type and default qualification length for
//               the push-button debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package btn_debouncer_pkg;

    // 10 ms of stable level at a 100 MHz system clock
    localparam int unsigned CNT_MAX_DEFAULT = 1_000_000;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_e;

endpackage : btn_debouncer_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous input bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/btn_debouncer.sv
// ============================================================================
// Module      : btn_debouncer
// Description : Synchronises and debounces a mechanical push-button, with
//               registered level output and one-cycle rise/fall strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic rise,
    output logic fall
);

    localparam int unsigned           c_CNT_W    = $clog2(CNT_MAX);
    localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(CNT_MAX - 1);

    logic               w_btn_s;
    db_state_e          r_state;
    db_state_e          w_state_nx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nx;
    logic               r_btn_db;
    logic               r_rise;
    logic               r_fall;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (w_btn_s)
    );

    // Any return to the old level drops back to STABLE_* with the count cleared,
    // so a later attempt always qualifies from zero.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = '0;
        case (r_state)
            STABLE_LO: begin
                if (w_btn_s) w_state_nx = WAIT_HI;
            end
            WAIT_HI: begin
                if (!w_btn_s)                 w_state_nx = STABLE_LO;
                else if (r_cnt == c_CNT_LAST) w_state_nx = STABLE_HI;
                else                          w_cnt_nx   = r_cnt + 1'b1;
            end
            STABLE_HI: begin
                if (!w_btn_s) w_state_nx = WAIT_LO;
            end
            WAIT_LO: begin
                if (w_btn_s)                  w_state_nx = STABLE_HI;
                else if (r_cnt == c_CNT_LAST) w_state_nx = STABLE_LO;
                else                          w_cnt_nx   = r_cnt + 1'b1;
            end
            default: begin
                w_state_nx = STABLE_LO;
            end
        endcase
    end

    // Outputs are registered from the next state so btn_db changes on the
    // same edge the FSM enters the new stable state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= STABLE_LO;
            r_cnt    <= '0;
            r_btn_db <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_btn_db <= (w_state_nx == STABLE_HI) || (w_state_nx == WAIT_LO);
            r_rise   <= (r_state == WAIT_HI) && (w_state_nx == STABLE_HI);
            r_fall   <= (r_state == WAIT_LO) && (w_state_nx == STABLE_LO);
        end
    end

    assign btn_db = r_btn_db;
    assign rise   = r_rise;
    assign fall   = r_fall;

endmodule : btn_debouncer

`default_nettype wire

// File: tb/tb_btn_debouncer.sv
// ============================================================================
// Module      : tb_btn_debouncer
// Description : Self-checking bench for btn_debouncer (CNT_MAX=4, 10 ns clk).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_btn_debouncer;

    localparam int unsigned CNT_MAX = 4;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_db;
    logic rise;
    logic fall;

    int checks   = 0;
    int failures = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    always #5 clk = ~clk;

    btn_debouncer #(.CNT_MAX(CNT_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .btn_db  (btn_db),
        .rise    (rise),
        .fall    (fall)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: the raw level reaches the decision point two edges late; the
    // output flips once the delayed level has disagreed with it on CNT_MAX+1
    // consecutive sampling edges.
    logic m_pipe [2] = '{1'b0, 1'b0};
    int   m_run      = 0;
    logic m_db       = 1'b0;
    logic m_rise     = 1'b0;
    logic m_fall     = 1'b0;

    always @(posedge clk or negedge rst) begin
        logic seen;
        if (!rst) begin
            m_pipe = '{1'b0, 1'b0};
            m_run  = 0;
            m_db   = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
        end else begin
            seen      = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = btn_raw;
            m_rise    = 1'b0;
            m_fall    = 1'b0;
            m_run     = (seen != m_db) ? m_run + 1 : 0;
            if (m_run == CNT_MAX + 1) begin
                m_rise = seen;
                m_fall = !seen;
                m_db   = seen;
                m_run  = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_btn_db", btn_db, m_db);
        check("model_rise", rise, m_rise);
        check("model_fall", fall, m_fall);
        check("rise_fall_exclusive", rise & fall, 1'b0);
        if (rise) rise_cnt++;
        if (fall) fall_cnt++;
    end

    // Called right after btn_raw (or rst) changed at a negedge: btn_db must
    // still be old after edge 6 and take the new level at edge 7 with one strobe.
    task automatic expect_flip(input string name, input logic level);
        repeat (CNT_MAX + 2) @(posedge clk);
        @(negedge clk);
        check({name, "_db_before"}, btn_db, !level);
        check({name, "_strobe_before"}, rise | fall, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check({name, "_db_at7"}, btn_db, level);
        check({name, "_rise_at7"}, rise, level);
        check({name, "_fall_at7"}, fall, !level);
        @(posedge clk);
        @(negedge clk);
        check({name, "_strobe_after"}, rise | fall, 1'b0);
        check({name, "_db_after"}, btn_db, level);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int r0;
        int f0;

        // Reset held with the button already pressed
        btn_raw = 1'b1;
        @(negedge clk);
        check("reset_db", btn_db, 1'b0);
        check("reset_rise", rise, 1'b0);
        check("reset_fall", fall, 1'b0);
        @(negedge clk);
        r0  = rise_cnt;
        rst = 1'b1;
        expect_flip("rst_release", 1'b1);
        check_int("rst_release_rise_count", rise_cnt - r0, 1);
        hold(3);

        // Clean release then clean press/release
        btn_raw = 1'b0;
        expect_flip("clean_release0", 1'b0);
        hold(2);
        btn_raw = 1'b1;
        expect_flip("clean_press", 1'b1);
        hold(2);
        btn_raw = 1'b0;
        expect_flip("clean_release", 1'b0);
        hold(3);

        // Bounce 1,0,1,0 at 20 ns then hold high
        r0 = rise_cnt;
        for (int i = 0; i < 4; i++) begin
            btn_raw = (i % 2 == 0);
            hold(2);
            check("bounce_db_low", btn_db, 1'b0);
        end
        btn_raw = 1'b1;
        expect_flip("bounce", 1'b1);
        check_int("bounce_rise_count", rise_cnt - r0, 1);
        hold(2);
        btn_raw = 1'b0;
        expect_flip("bounce_release", 1'b0);
        hold(3);

        // Three-cycle glitch must be ignored
        r0 = rise_cnt;
        f0 = fall_cnt;
        btn_raw = 1'b1;
        hold(3);
        btn_raw = 1'b0;
        hold(12);
        check("glitch_db", btn_db, 1'b0);
        check_int("glitch_rise_count", rise_cnt - r0, 0);
        check_int("glitch_fall_count", fall_cnt - f0, 0);

        // Reset in the middle of qualifying a press
        btn_raw = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_db", btn_db, 1'b0);
        check("midrst_rise", rise, 1'b0);
        check("midrst_fall", fall, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        expect_flip("midrst_release", 1'b1);
        hold(2);
        btn_raw = 1'b0;
        expect_flip("midrst_drop", 1'b0);
        hold(2);

        // 500 ns bouncy press: short bounces, then settled high
        r0 = rise_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_raw = ~btn_raw;
            hold(int'($urandom_range(1, 2)));
        end
        btn_raw = 1'b1;
        hold(50 - 15);
        check("bouncy_press_db", btn_db, 1'b1);
        check_int("bouncy_press_single_rise", rise_cnt - r0, 1);
        btn_raw = 1'b0;
        hold(12);

        // Randomised levels/hold times with occasional asynchronous resets
        for (int seg = 0; seg < 300; seg++) begin
            btn_raw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                #($urandom_range(1, 8));
                rst = 1'b0;
                @(negedge clk);
                hold(int'($urandom_range(0, 2)));
                rst = 1'b1;
            end
            hold(int'($urandom_range(1, 9)));
        end
        hold(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_btn_debouncer

`default_nettype wire
